// File: rtl/rr_decode_arbiter_if.sv
// Request/grant bundle for rr_decode_arbiter.
// master = arbiter side, slave = requester/decoder side.
interface rr_decode_arbiter_if;
  logic       en;
  logic [7:0] req;
  logic       a;
  logic       b;
  logic       c;
  logic [7:0] gnt;
  logic       gnt_vld;
  logic [7:0] hold_cnt;

  modport master (
    input  en, req,
    output a, b, c, gnt, gnt_vld, hold_cnt
  );

  modport slave (
    output en, req,
    input  a, b, c, gnt, gnt_vld, hold_cnt
  );
endinterface

// File: rtl/rr_decode_arbiter.sv
// Eight-way round-robin arbiter with 3-bit select and one-hot grant.
// Define RR_HOLD_LIMIT_EN to cap each tenure at MAX_HOLD cycles.
module rr_decode_arbiter #(
  parameter int MAX_HOLD = 4
) (
  input logic                  clk,
  input logic                  rst,
  rr_decode_arbiter_if.master  bus
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t     state;
  logic [2:0] ptr;
  logic [2:0] sel;
  logic [7:0] gnt_q;
  logic       vld_q;
  logic [7:0] hc_q;

  logic [7:0] mask;
  logic [2:0] idx;
  logic [2:0] win;
  logic       found;
  logic       at_lim;
  logic       keep;

`ifdef RR_HOLD_LIMIT_EN
  assign at_lim = (hc_q == 8'(MAX_HOLD - 1));
`else
  assign at_lim = 1'b0;
`endif

  assign keep = bus.req[sel] & ~at_lim;

  // Current owner is excluded so a handover never re-picks it.
  always_comb begin
    mask  = bus.req;
    found = 1'b0;
    win   = ptr;
    idx   = '0;
    if (state == GRANT) mask[sel] = 1'b0;
    for (int k = 8; k >= 1; k--) begin
      idx = ptr + 3'(k);
      if (mask[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= 3'd7;
      sel   <= 3'd0;
      gnt_q <= 8'h00;
      vld_q <= 1'b0;
      hc_q  <= 8'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.en && found) begin
            state <= GRANT;
            ptr   <= win;
            sel   <= win;
            gnt_q <= 8'd1 << win;
            vld_q <= 1'b1;
            hc_q  <= 8'd0;
          end
        end
        GRANT: begin
          if (keep) begin
            if (hc_q != 8'hFF) hc_q <= hc_q + 8'd1;
          end else if (bus.en && found) begin
            ptr   <= win;
            sel   <= win;
            gnt_q <= 8'd1 << win;
            hc_q  <= 8'd0;
          end else if (bus.req[sel]) begin
            hc_q  <= 8'd0;
          end else begin
            state <= IDLE;
            gnt_q <= 8'h00;
            vld_q <= 1'b0;
            hc_q  <= 8'd0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.a        = sel[2];
  assign bus.b        = sel[1];
  assign bus.c        = sel[0];
  assign bus.gnt      = gnt_q;
  assign bus.gnt_vld  = vld_q;
  assign bus.hold_cnt = hc_q;

endmodule
